// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// IF-stage front-end control for the 5-stage MIPS pipeline. It arbitrates
// redirects from EX (taken branches) and ID (jumps), parks a redirect that
// arrives while instruction memory is not ready, and drives the PC's
// stall / jump_cs / Next_pc inputs. It also produces the IF/ID and ID/EX
// hold/flush strobes and two saturating performance counters.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_ready         instruction memory can return an instruction this cycle
//   load_use_hazard    load in EX feeds the instruction in ID
//   jmp_req/jmp_target ID-stage jump resolved this cycle and its target
//   br_taken/br_target EX-stage taken branch and its target
//   stall, jump_cs     to PC: hold pc_curr / load Next_pc
//   Next_pc            to PC: word-aligned redirect target (0 when idle)
//   hold_ifid          IF/ID keeps its contents
//   flush_ifid         IF/ID loads a bubble
//   flush_idex         ID/EX loads a bubble
//   misalign_err       registered pulse: winning target had nonzero [1:0]
//   stall_cnt          saturating count of stall cycles
//   redirect_cnt       saturating count of accepted redirects
module fetch_redirect_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_ready,
    input  logic              load_use_hazard,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              stall,
    output logic              jump_cs,
    output logic [ADDR_W-1:0] Next_pc,
    output logic              hold_ifid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              req_valid;
    logic [ADDR_W-1:0] req_target;
    logic              jmp_live;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    // A jump is wrong-path when a redirect is already parked, and is itself
    // frozen in ID while a load-use hazard holds it there.
    assign jmp_live = jmp_req & ~load_use_hazard & ~pend_valid;

    // Branch is the oldest request, then the parked redirect, then a live jump.
    always_comb begin
        req_valid  = 1'b0;
        req_target = '0;
        if (rst_n) begin
            if (br_taken) begin
                req_valid  = 1'b1;
                req_target = br_target;
            end else if (pend_valid) begin
                req_valid  = 1'b1;
                req_target = pend_target;
            end else if (jmp_live) begin
                req_valid  = 1'b1;
                req_target = jmp_target;
            end
        end
    end

    assign Next_pc    = req_valid ? {req_target[ADDR_W-1:2], 2'b00} : '0;
    assign stall      = ~rst_n | ~imem_ready | (load_use_hazard & ~req_valid);
    assign jump_cs    = req_valid & imem_ready & rst_n;
    assign hold_ifid  = rst_n & load_use_hazard & ~req_valid;
    // Flushes fire in the request cycle even if the PC cannot take the
    // redirect yet; the parked target carries the redirect forward.
    assign flush_ifid = rst_n & (br_taken | jmp_live);
    assign flush_idex = rst_n & (br_taken | load_use_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (req_valid && !imem_ready) begin
            pend_valid  <= 1'b1;
            pend_target <= req_target;
        end else if (req_valid && imem_ready) begin
            pend_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= req_valid & (req_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (jump_cs && !stall) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_ready = 1'b1;
    logic              load_use_hazard = 1'b0;
    logic              jmp_req = 1'b0;
    logic [ADDR_W-1:0] jmp_target = '0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              stall, jump_cs, hold_ifid, flush_ifid, flush_idex, misalign_err;
    logic [ADDR_W-1:0] Next_pc;
    logic [CNT_W-1:0]  stall_cnt, redirect_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    fetch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
        .load_use_hazard(load_use_hazard), .jmp_req(jmp_req),
        .jmp_target(jmp_target), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .jump_cs(jump_cs), .Next_pc(Next_pc),
        .hold_ifid(hold_ifid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .misalign_err(misalign_err), .stall_cnt(stall_cnt),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_use_hazard = 1'b0;
        jmp_req = 1'b0;
        br_taken = 1'b0;
        imem_ready = 1'b1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Reference model: at most one parked redirect target kept in a queue,
    // counters as plain saturating integers.
    int unsigned pq[$];
    int          m_scnt = 0;
    int          m_rcnt = 0;
    bit          m_mis  = 1'b0;

    initial begin : compare
        bit          have_p, win, e_stall, e_jcs;
        int unsigned tgt;
        int unsigned nx_t;
        bit          nx_pv, nx_mis;
        int          nx_s, nx_r;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (!rst_n) begin
                pq.delete();
                m_scnt = 0;
                m_rcnt = 0;
                m_mis  = 1'b0;
            end
            check("misalign_err", misalign_err, m_mis);
            check("stall_cnt", stall_cnt, m_scnt);
            check("redirect_cnt", redirect_cnt, m_rcnt);

            have_p = (pq.size() != 0);
            win = 1'b0;
            tgt = 0;
            if (rst_n) begin
                if (br_taken) begin
                    win = 1'b1; tgt = br_target;
                end else if (have_p) begin
                    win = 1'b1; tgt = pq[0];
                end else if (jmp_req && !load_use_hazard) begin
                    win = 1'b1; tgt = jmp_target;
                end
            end
            e_stall = !rst_n || !imem_ready || (load_use_hazard && !win);
            e_jcs   = rst_n && win && imem_ready;
            check("Next_pc", Next_pc, win ? (tgt & 32'hFFFF_FFFC) : 0);
            check("stall", stall, e_stall);
            check("jump_cs", jump_cs, e_jcs);
            check("hold_ifid", hold_ifid, rst_n && load_use_hazard && !win);
            check("flush_ifid", flush_ifid,
                  rst_n && (br_taken || (jmp_req && !load_use_hazard && !have_p)));
            check("flush_idex", flush_idex, rst_n && (br_taken || load_use_hazard));

            nx_pv  = have_p;
            nx_t   = have_p ? pq[0] : 0;
            if (win && !imem_ready) begin
                nx_pv = 1'b1; nx_t = tgt;
            end else if (win) begin
                nx_pv = 1'b0;
            end
            nx_mis = win && ((tgt & 3) != 0);
            nx_s   = (e_stall && rst_n) ? ((m_scnt < CMAX) ? m_scnt + 1 : CMAX) : m_scnt;
            nx_r   = (e_jcs && !e_stall) ? ((m_rcnt < CMAX) ? m_rcnt + 1 : CMAX) : m_rcnt;

            @(posedge clk);
            if (rst_n) begin
                pq.delete();
                if (nx_pv) pq.push_back(nx_t);
                m_mis  = nx_mis;
                m_scnt = nx_s;
                m_rcnt = nx_r;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] t;
        // Reset state
        @(negedge clk);
        check("rst_stall", stall, 1);
        check("rst_jump_cs", jump_cs, 0);
        check("rst_Next_pc", Next_pc, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        do_reset();

        // Plain jump
        jmp_req = 1'b1; jmp_target = 32'h0040_0100;
        @(negedge clk);
        check("jmp_jump_cs", jump_cs, 1);
        check("jmp_stall", stall, 0);
        check("jmp_Next_pc", Next_pc, 32'h0040_0100);
        check("jmp_flush_ifid", flush_ifid, 1);
        step(); idle_inputs();
        @(negedge clk);
        check("jmp_redirect_cnt", redirect_cnt, 1);
        check("jmp_after_jcs", jump_cs, 0);

        // Branch under memory wait
        do_reset();
        br_taken = 1'b1; br_target = 32'h200; imem_ready = 1'b0;
        @(negedge clk);
        check("wait1_stall", stall, 1);
        check("wait1_jcs", jump_cs, 0);
        step(); br_taken = 1'b0;
        @(negedge clk);
        check("wait2_jcs", jump_cs, 0);
        step();
        @(negedge clk);
        check("wait3_stall", stall, 1);
        step(); imem_ready = 1'b1;
        @(negedge clk);
        check("wait4_jcs", jump_cs, 1);
        check("wait4_Next_pc", Next_pc, 32'h200);
        check("wait4_stall", stall, 0);
        step();
        @(negedge clk);
        check("wait_stall_cnt", stall_cnt, 3);
        check("wait_redirect_cnt", redirect_cnt, 1);
        check("wait_once", jump_cs, 0);

        // Load-use with a jump in ID
        do_reset();
        load_use_hazard = 1'b1; jmp_req = 1'b1; jmp_target = 32'h1000;
        @(negedge clk);
        check("lu_stall", stall, 1);
        check("lu_hold", hold_ifid, 1);
        check("lu_flush_idex", flush_idex, 1);
        check("lu_jcs", jump_cs, 0);
        check("lu_flush_ifid", flush_ifid, 0);
        step(); load_use_hazard = 1'b0;
        @(negedge clk);
        check("lu_jump_taken", jump_cs, 1);
        check("lu_Next_pc", Next_pc, 32'h1000);

        // Pending jump overwritten by branch; later jump ignored
        do_reset();
        jmp_req = 1'b1; jmp_target = 32'h300; imem_ready = 1'b0;
        step(); jmp_req = 1'b0; br_taken = 1'b1; br_target = 32'h500;
        step(); br_taken = 1'b0; jmp_req = 1'b1; jmp_target = 32'h700;
        @(negedge clk);
        check("prio_Next_pc_wait", Next_pc, 32'h500);
        check("prio_flush_ifid", flush_ifid, 0);
        step(); jmp_req = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        check("prio_jcs", jump_cs, 1);
        check("prio_Next_pc", Next_pc, 32'h500);
        step();
        @(negedge clk);
        check("prio_once", jump_cs, 0);
        check("prio_redirect_cnt", redirect_cnt, 1);

        // Misaligned target
        do_reset();
        jmp_req = 1'b1; jmp_target = 32'h0000_0102;
        @(negedge clk);
        check("mis_Next_pc", Next_pc, 32'h100);
        check("mis_err_early", misalign_err, 0);
        step(); jmp_req = 1'b0;
        @(negedge clk);
        check("mis_err", misalign_err, 1);
        step();
        @(negedge clk);
        check("mis_err_one", misalign_err, 0);

        // Asynchronous reset while a redirect is parked
        do_reset();
        jmp_req = 1'b1; jmp_target = 32'h300; imem_ready = 1'b0;
        step(); jmp_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall", stall, 1);
        check("arst_Next_pc", Next_pc, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_jcs", jump_cs, 0);
        step(); rst_n = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        check("arst_dropped", jump_cs, 0);
        check("arst_no_stall", stall, 0);

        // Counter saturation
        do_reset();
        imem_ready = 1'b0;
        repeat (20) step();
        imem_ready = 1'b1;
        @(negedge clk);
        check("sat_stall_cnt", stall_cnt, 15);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n           = ($urandom_range(0, 99) != 0);
            imem_ready      = ($urandom_range(0, 9) < 7);
            load_use_hazard = ($urandom_range(0, 9) < 2);
            jmp_req         = ($urandom_range(0, 9) < 3);
            br_taken        = ($urandom_range(0, 19) < 3);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            jmp_target = t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            br_target = t;
        end
        step();
        idle_inputs();
        rst_n = 1'b1;
        step();
        done = 1'b1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
